// File: rtl/jtframe_i2s_tx.sv
// I2S transmitter: captures stereo samples into a one-entry holding register
// and serialises them MSB first at a fixed frame rate (left slot, then right slot).
// lrclk leads data by one bit clock, and data changes on bclk falling edges.
module jtframe_i2s_tx #(
    parameter int DW         = 16,
    parameter int SLOTW      = 32,
    parameter int BDIV       = 8,
    parameter int SIGNED_SND = 1,
    parameter int ATT        = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] snd_left,
    input  logic [DW-1:0] snd_right,
    input  logic          sample,
    input  logic          mute,
    output logic          i2s_bclk,
    output logic          i2s_lrclk,
    output logic          i2s_data,
    output logic          frame_st,
    output logic          overrun
);
    localparam int BW  = $clog2(2*SLOTW);
    localparam int DVW = $clog2(BDIV);
    localparam int PW  = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [DVW-1:0] DIV_LAST = DVW'(BDIV-1);
    localparam logic [BW-1:0]  B_RESET  = BW'(2*SLOTW-2);
    localparam logic [BW-1:0]  B_LAST   = BW'(2*SLOTW-1);
    localparam logic [BW-1:0]  B_SLOT   = BW'(SLOTW);
    localparam logic [BW-1:0]  B_LR_ON  = BW'(SLOTW-1);
    localparam logic [BW-1:0]  B_DW     = BW'(DW);

    logic              r_sample_d;
    logic [2*DW-1:0]   r_hold;
    logic              r_pending;
    logic              r_overrun;
    logic [2*DW-1:0]   r_shift;
    logic              r_mute_q;
    logic [DVW-1:0]    r_div;
    logic              r_bclk;
    logic [BW-1:0]     r_b;
    logic              r_lrclk;
    logic              r_data;
    logic              r_frame_st;

    logic [DW-1:0]        w_left_fmt;
    logic [DW-1:0]        w_right_fmt;
    logic signed [DW-1:0] w_left_cap;
    logic signed [DW-1:0] w_right_cap;
    logic                 w_edge;
    logic                 w_div_wrap;
    logic                 w_fall;
    logic [BW-1:0]        w_b_next;
    logic                 w_load;
    logic                 w_right;
    logic [BW-1:0]        w_pos;
    logic                 w_lr_next;
    logic                 w_bit_next;
    logic [DW-1:0]        w_left_rev;
    logic [DW-1:0]        w_right_rev;

    // Sample formatting: optional unsigned-to-signed MSB flip, then attenuation
    always_comb begin
        w_left_fmt  = snd_left;
        w_right_fmt = snd_right;
        if (SIGNED_SND == 0) begin
            w_left_fmt[DW-1]  = ~snd_left[DW-1];
            w_right_fmt[DW-1] = ~snd_right[DW-1];
        end
        w_left_cap  = $signed(w_left_fmt) >>> ATT;
        w_right_cap = $signed(w_right_fmt) >>> ATT;
    end

    assign w_edge     = sample & ~r_sample_d;
    assign w_div_wrap = (r_div == DIV_LAST);
    assign w_fall     = w_div_wrap & r_bclk;
    assign w_b_next   = (r_b == B_LAST) ? '0 : r_b + BW'(1);
    assign w_load     = w_fall & (w_b_next == B_LAST);

    // Bit-reversed views of the frame word so slot position indexes directly
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_rev
            assign w_left_rev[gi]  = r_shift[2*DW-1-gi];
            assign w_right_rev[gi] = r_shift[DW-1-gi];
        end
    endgenerate

    assign w_right   = (w_b_next >= B_SLOT);
    assign w_pos     = w_right ? (w_b_next - B_SLOT) : w_b_next;
    assign w_lr_next = (w_b_next >= B_LR_ON) && (w_b_next != B_LAST);

    // Next serial bit; slot padding and muted frames send zeros
    always_comb begin
        w_bit_next = 1'b0;
        if (!r_mute_q && (w_pos < B_DW))
            w_bit_next = w_right ? w_right_rev[w_pos[PW-1:0]] : w_left_rev[w_pos[PW-1:0]];
    end

    // Capture path: edge detect, holding register, pending flag and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_d <= 1'b0;
            r_hold     <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sample_d <= sample;
            if (w_edge) begin
                r_hold    <= {w_left_cap, w_right_cap};
                r_pending <= 1'b1;
                // A load in the same cycle consumes the old word, so nothing is lost
                if (r_pending && !w_load)
                    r_overrun <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Frame load: take the new word if one is pending, else repeat the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_mute_q <= 1'b0;
        end else if (w_load) begin
            r_shift  <= r_pending ? r_hold : r_shift;
            r_mute_q <= mute;
        end
    end

    // Bit clock generation, slot bit counter and serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_bclk     <= 1'b0;
            r_b        <= B_RESET;
            r_lrclk    <= 1'b0;
            r_data     <= 1'b0;
            r_frame_st <= 1'b0;
        end else begin
            r_frame_st <= w_load;
            if (w_div_wrap) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + DVW'(1);
            end
            if (w_fall) begin
                r_b     <= w_b_next;
                r_lrclk <= w_lr_next;
                r_data  <= w_bit_next;
            end
        end
    end

    assign i2s_bclk  = r_bclk;
    assign i2s_lrclk = r_lrclk;
    assign i2s_data  = r_data;
    assign frame_st  = r_frame_st;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// Bench for jtframe_i2s_tx: a time-based model (bclk phase, slot position and
// frame word derived from the clock count since reset) is compared every cycle
// against two instances (signed/no attenuation and unsigned/ATT=1), plus
// directed scenarios with literal expected frames and timings.
module tb_jtframe_i2s_tx;
    localparam int DW    = 16;
    localparam int SLOTW = 32;
    localparam int BDIV  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] snd_left = '0;
    logic [DW-1:0] snd_right = '0;
    logic          sample = 1'b0;
    logic          mute = 1'b0;

    logic s_bclk, s_lrclk, s_data, s_frame_st, s_overrun;
    logic u_bclk, u_lrclk, u_data, u_frame_st, u_overrun;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    jtframe_i2s_tx #(.DW(DW), .SLOTW(SLOTW), .BDIV(BDIV), .SIGNED_SND(1), .ATT(0)) dut (
        .clk(clk), .rst_n(rst_n), .snd_left(snd_left), .snd_right(snd_right),
        .sample(sample), .mute(mute), .i2s_bclk(s_bclk), .i2s_lrclk(s_lrclk),
        .i2s_data(s_data), .frame_st(s_frame_st), .overrun(s_overrun)
    );

    jtframe_i2s_tx #(.DW(DW), .SLOTW(SLOTW), .BDIV(BDIV), .SIGNED_SND(0), .ATT(1)) dut_u (
        .clk(clk), .rst_n(rst_n), .snd_left(snd_left), .snd_right(snd_right),
        .sample(sample), .mute(mute), .i2s_bclk(u_bclk), .i2s_lrclk(u_lrclk),
        .i2s_data(u_data), .frame_st(u_frame_st), .overrun(u_overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int            k = 0;
    logic [31:0]   hold_s = '0, hold_u = '0, word_s = '0, word_u = '0;
    bit            pend = 0, ovr = 0, mute_f = 0, prev_sample = 0;

    function automatic logic [15:0] fmt_u(input logic [15:0] x);
        logic signed [15:0] t;
        t = $signed({~x[15], x[14:0]});
        return 16'(t >>> 1);
    endfunction

    // {bclk, lrclk, data, frame_st, overrun} expected k clocks after reset release
    function automatic logic [4:0] model_out(input int kk, input logic [31:0] w,
                                             input bit mf, input bit ov);
        int  m, b, p;
        logic d, lr, bc, fs;
        bc = ((kk / BDIV) % 2) == 1;
        m  = kk / (2*BDIV);
        fs = (kk > 0) && (kk % (2*BDIV) == 0) && (m % (2*SLOTW) == 1);
        d  = 1'b0;
        lr = 1'b0;
        if (m > 0) begin
            b  = (2*SLOTW - 2 + m) % (2*SLOTW);
            lr = (b >= SLOTW-1) && (b != 2*SLOTW-1);
            p  = (b < SLOTW) ? b : b - SLOTW;
            if (!mf && p < DW)
                d = (b < SLOTW) ? w[2*DW-1-p] : w[DW-1-p];
        end
        return {bc, lr, d, fs, ov};
    endfunction

    initial begin : monitor
        bit ld, ed;
        logic [4:0] exp_s, exp_u;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k = 0; hold_s = '0; hold_u = '0; word_s = '0; word_u = '0;
                pend = 0; ovr = 0; mute_f = 0; prev_sample = 0;
            end else begin
                k++;
                ld = (k % (2*BDIV) == 0) && ((k / (2*BDIV)) % (2*SLOTW) == 1);
                ed = sample && !prev_sample;
                prev_sample = sample;
                if (ld) begin
                    if (pend) begin word_s = hold_s; word_u = hold_u; end
                    mute_f = mute;
                    pend   = 0;
                end
                if (ed) begin
                    if (pend) ovr = 1;
                    hold_s = {snd_left, snd_right};
                    hold_u = {fmt_u(snd_left), fmt_u(snd_right)};
                    pend   = 1;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                exp_s = '0; exp_u = '0;
            end else begin
                exp_s = model_out(k, word_s, mute_f, ovr);
                exp_u = model_out(k, word_u, mute_f, ovr);
            end
            check("cycle_signed", 64'({s_bclk, s_lrclk, s_data, s_frame_st, s_overrun}), 64'(exp_s));
            check("cycle_unsigned", 64'({u_bclk, u_lrclk, u_data, u_frame_st, u_overrun}), 64'(exp_u));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int cnt);
        cnt = 0;
        do begin step(); cnt++; end while (!s_frame_st && cnt < 1000);
        if (cnt >= 1000) check("frame_st_timeout", 64'(cnt), 64'(0));
    endtask

    task automatic wait_rise(output int cnt);
        logic pb;
        cnt = 0;
        do begin pb = s_bclk; step(); cnt++; end while (!(s_bclk && !pb) && cnt < 100);
    endtask

    // Collects slot bits b=0..2*SLOTW-1 of the frame loaded at the current/next frame_st
    task automatic get_frame(output logic [63:0] fs, output logic [63:0] fu);
        int   n, guard;
        logic pb;
        fs = '0; fu = '0; guard = 0;
        while (!s_frame_st && guard < 600) begin step(); guard++; end
        n = -1;
        pb = s_bclk;
        while (n < 64 && guard < 1200) begin
            step(); guard++;
            if (s_bclk && !pb) begin
                if (n >= 0) begin
                    fs = {fs[62:0], s_data};
                    fu = {fu[62:0], u_data};
                end
                n++;
            end
            pb = s_bclk;
        end
        if (guard >= 1200) check("get_frame_timeout", 64'(guard), 64'(0));
        $display("frame collected at %0t: signed=%h unsigned=%h", $time, fs, fu);
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        snd_left = l; snd_right = r; sample = 1'b1;
        step();
        sample = 1'b0;
        step();
    endtask

    initial begin : stim
        int cnt;
        logic [63:0] fs, fu;

        // Test 1: capture before the first load, check the serial pattern
        snd_left = 16'h8001; snd_right = 16'h7FFE;
        repeat (3) step();
        rst_n = 1'b1; sample = 1'b1;
        wait_frame(cnt);
        check("first_load_delay", 64'(cnt), 64'd4);
        sample = 1'b0;
        get_frame(fs, fu);
        check("t1_frame", fs, {32'h8001_0000, 32'h7FFE_0000});

        // Test 2: free-running timing
        wait_frame(cnt);
        wait_frame(cnt);
        check("frame_period", 64'(cnt), 64'd256);
        step();
        check("frame_st_width", 64'(s_frame_st), 64'd0);
        wait_rise(cnt);
        wait_rise(cnt);
        check("bclk_period", 64'(cnt), 64'd4);

        // Test 3: one capture, repeated over three frames
        strobe(16'h1234, 16'hABCD);
        for (int i = 0; i < 3; i++) begin
            get_frame(fs, fu);
            check("t3_repeat", fs, {16'h1234, 16'h0, 16'hABCD, 16'h0});
        end
        check("t3_overrun", 64'(s_overrun), 64'd0);

        // Test 5: capture edge in the same clk as a frame load
        wait_frame(cnt);
        snd_left = 16'h5555; snd_right = 16'h6666;
        repeat (255) step();
        sample = 1'b1;
        step();
        check("t5_load_align", 64'(s_frame_st), 64'd1);
        sample = 1'b0;
        get_frame(fs, fu);
        check("t5_old_word", fs, {16'h1234, 16'h0, 16'hABCD, 16'h0});
        get_frame(fs, fu);
        check("t5_new_word", fs, {16'h5555, 16'h0, 16'h6666, 16'h0});
        check("t5_overrun", 64'(s_overrun), 64'd0);

        // Test 4: two captures within one frame
        wait_frame(cnt);
        repeat (10) step();
        strobe(16'h1111, 16'h2222);
        strobe(16'h3333, 16'h4444);
        get_frame(fs, fu);
        check("t4_latest_word", fs, {16'h3333, 16'h0, 16'h4444, 16'h0});
        check("t4_overrun", 64'(s_overrun), 64'd1);

        // Test 7: muted frame, then resume the held word
        mute = 1'b1;
        get_frame(fs, fu);
        check("t7_muted", fs, 64'h0);
        mute = 1'b0;
        get_frame(fs, fu);
        check("t7_resume", fs, {16'h3333, 16'h0, 16'h4444, 16'h0});
        check("t7_overrun_sticky", 64'(s_overrun), 64'd1);

        // Test 6: unsigned input with attenuation
        strobe(16'h0000, 16'h0000);
        get_frame(fs, fu);
        check("t6_signed_zero", fs, 64'h0);
        check("t6_unsigned_att", fu, {16'hC000, 16'h0, 16'hC000, 16'h0});

        // Test 8: reset mid-frame
        wait_frame(cnt);
        repeat (100) step();
        rst_n = 1'b0;
        #1;
        check("t8_async_reset", 64'({s_bclk, s_lrclk, s_data, s_frame_st, s_overrun}), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        wait_frame(cnt);
        check("t8_first_load_delay", 64'(cnt), 64'd4);
        wait_frame(cnt);
        check("t8_frame_period", 64'(cnt), 64'd256);
        check("t8_overrun_cleared", 64'(s_overrun), 64'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
